// File: rtl/dino_pkg.sv
// Shared definitions for the dino game: danger type encodings, sprite geometry
// and the vertical reference lines used by both the spawner and the renderer.
package dino_pkg;

  typedef enum logic [2:0] {
    LOW_BIRD     = 3'd0,
    HIGH_BIRD    = 3'd1,
    SMALL_CACTUS = 3'd2,
    MANY_CACTUS  = 3'd3,
    BIG_CACTUS   = 3'd4,
    NOTHING      = 3'd5
  } danger_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } spawner_state_t;

  localparam int BIRD_W         = 46;
  localparam int BIRD_H         = 40;
  localparam int SMALL_CACTUS_W = 17;
  localparam int SMALL_CACTUS_H = 35;
  localparam int MANY_CACTUS_W  = 51;
  localparam int MANY_CACTUS_H  = 35;
  localparam int BIG_CACTUS_W   = 25;
  localparam int BIG_CACTUS_H   = 50;

  localparam logic [9:0] GROUND   = 10'd420;
  localparam logic [9:0] LOW_SKY  = 10'd380;
  localparam logic [9:0] HIGH_SKY = 10'd330;

  // Folds the 8 LFSR codes onto the 5 spawnable types; birds optionally become cacti.
  function automatic danger_t pick_type(input logic [2:0] t, input logic bird_en);
    logic [2:0] r;
    case (t)
      3'd5:    r = 3'd1;
      3'd6:    r = 3'd2;
      3'd7:    r = 3'd3;
      default: r = t;
    endcase
    if (!bird_en && (r <= 3'd1)) r = r + 3'd2;
    return danger_t'(r);
  endfunction

endpackage

// File: rtl/danger_lfsr.sv
// 16-bit Galois LFSR (taps 0xB400), free-running, seed loaded on synchronous reset.
module danger_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] lfsr
);

  always_ff @(posedge clk) begin
    if (rst) lfsr <= SEED;
    else     lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  end

endmodule

// File: rtl/danger_spawner.sv
// Obstacle generator: three danger slots spawned pseudo-randomly, scrolled left
// once per frame tick and retired at the left edge. All outputs are registered.
module danger_spawner
  import dino_pkg::*;
#(
  parameter int          SPAWN_X = 700,
  parameter int          GAP_MIN = 40,
  parameter logic [15:0] SEED    = 16'hACE1,
  parameter bit          BIRD_EN = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           tick,
  input  logic           start,
  input  logic           halt,
  input  logic [3:0]     speed,
  output logic [9:0]     new_danger_pos1,
  output logic [9:0]     new_danger_pos2,
  output logic [9:0]     new_danger_pos3,
  output logic [2:0]     danger_type1,
  output logic [2:0]     danger_type2,
  output logic [2:0]     danger_type3,
  output logic           danger_en1,
  output logic           danger_en2,
  output logic           danger_en3,
  output logic           running,
  output spawner_state_t state_dbg
);

  localparam int NSLOT = 3;

  spawner_state_t   state, state_n;
  logic [15:0]      lfsr;
  logic [NSLOT-1:0] en, en_n;
  logic [9:0]       pos   [NSLOT];
  logic [9:0]       pos_n [NSLOT];
  danger_t          typ   [NSLOT];
  danger_t          typ_n [NSLOT];
  logic [7:0]       gap, gap_n;
  logic             any_free;
  logic [1:0]       free_idx;
  logic             tick_go;
  logic             unused_lfsr_bits;

  assign unused_lfsr_bits = ^{lfsr[15:10], lfsr[3]};

  danger_lfsr #(.SEED(SEED)) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .lfsr (lfsr)
  );

  // Priority encoder: lowest-index free slot, judged before this tick's retirements.
  always_comb begin
    any_free = 1'b0;
    free_idx = 2'd0;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      if (!en[i]) begin
        any_free = 1'b1;
        free_idx = 2'(i);
      end
    end
  end

  always_comb begin
    state_n = state;
    en_n    = en;
    pos_n   = pos;
    typ_n   = typ;
    gap_n   = gap;
    tick_go = 1'b0;

    case (state)
      RUN: begin
        if (halt)      state_n = STOP;
        else if (tick) tick_go = 1'b1;
      end
      default: ;
    endcase

    // start overrides halt and tick in every state and always clears the field.
    if (start) begin
      state_n = RUN;
      tick_go = 1'b0;
      en_n    = '0;
      gap_n   = 8'(GAP_MIN);
      for (int i = 0; i < NSLOT; i++) begin
        pos_n[i] = '0;
        typ_n[i] = NOTHING;
      end
    end

    if (tick_go) begin
      for (int i = 0; i < NSLOT; i++) begin
        if (en[i]) begin
          if (pos[i] < {6'd0, speed}) begin
            en_n[i]  = 1'b0;
            pos_n[i] = '0;
            typ_n[i] = NOTHING;
          end else begin
            pos_n[i] = pos[i] - {6'd0, speed};
          end
        end
      end

      if (gap != 8'd0) begin
        gap_n = gap - 8'd1;
      end else if (any_free) begin
        en_n[free_idx]  = 1'b1;
        pos_n[free_idx] = 10'(SPAWN_X);
        typ_n[free_idx] = pick_type(lfsr[2:0], BIRD_EN);
        gap_n           = 8'(GAP_MIN) + {2'b00, lfsr[9:4]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      en    <= '0;
      gap   <= '0;
      for (int i = 0; i < NSLOT; i++) begin
        pos[i] <= '0;
        typ[i] <= NOTHING;
      end
    end else begin
      state <= state_n;
      en    <= en_n;
      gap   <= gap_n;
      pos   <= pos_n;
      typ   <= typ_n;
    end
  end

  assign new_danger_pos1 = pos[0];
  assign new_danger_pos2 = pos[1];
  assign new_danger_pos3 = pos[2];
  assign danger_type1    = typ[0];
  assign danger_type2    = typ[1];
  assign danger_type3    = typ[2];
  assign danger_en1      = en[0];
  assign danger_en2      = en[1];
  assign danger_en3      = en[2];
  assign running         = (state == RUN);
  assign state_dbg       = state;

endmodule

// File: tb/tb_danger_spawner.sv
// Directed bench for danger_spawner: reset, first spawn, scroll/retire, full slots,
// halt/restart, precedence and type mapping on two extra fast-spawning instances.
module tb_danger_spawner;
  import dino_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1, tick = 1'b0, start = 1'b0, halt = 1'b0;
  logic [3:0] speed = 4'd0;
  logic [9:0] pos1, pos2, pos3;
  logic [2:0] type1, type2, type3;
  logic       en1, en2, en3, running;
  spawner_state_t st;

  logic       t_rst = 1'b1, t_start = 1'b0, t_tick = 1'b0;
  logic [9:0] b1_p1, b1_p2, b1_p3, b0_p1, b0_p2, b0_p3;
  logic [2:0] b1_t1, b1_t2, b1_t3, b0_t1, b0_t2, b0_t3;
  logic       b1_e1, b1_e2, b1_e3, b0_e1, b0_e2, b0_e3, b1_run, b0_run;
  spawner_state_t b1_st, b0_st;

  int checks = 0;
  int failures = 0;

  danger_spawner dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .halt(halt), .speed(speed),
    .new_danger_pos1(pos1), .new_danger_pos2(pos2), .new_danger_pos3(pos3),
    .danger_type1(type1), .danger_type2(type2), .danger_type3(type3),
    .danger_en1(en1), .danger_en2(en2), .danger_en3(en3),
    .running(running), .state_dbg(st)
  );

  danger_spawner #(.GAP_MIN(0), .BIRD_EN(1'b1)) dut_b1 (
    .clk(clk), .rst(t_rst), .tick(t_tick), .start(t_start), .halt(1'b0), .speed(4'd15),
    .new_danger_pos1(b1_p1), .new_danger_pos2(b1_p2), .new_danger_pos3(b1_p3),
    .danger_type1(b1_t1), .danger_type2(b1_t2), .danger_type3(b1_t3),
    .danger_en1(b1_e1), .danger_en2(b1_e2), .danger_en3(b1_e3),
    .running(b1_run), .state_dbg(b1_st)
  );

  danger_spawner #(.GAP_MIN(0), .BIRD_EN(1'b0)) dut_b0 (
    .clk(clk), .rst(t_rst), .tick(t_tick), .start(t_start), .halt(1'b0), .speed(4'd15),
    .new_danger_pos1(b0_p1), .new_danger_pos2(b0_p2), .new_danger_pos3(b0_p3),
    .danger_type1(b0_t1), .danger_type2(b0_t2), .danger_type3(b0_t3),
    .danger_en1(b0_e1), .danger_en2(b0_e2), .danger_en3(b0_e3),
    .running(b0_run), .state_dbg(b0_st)
  );

  // Reference LFSR for the main instance, tracking it edge for edge.
  function automatic logic [15:0] model_step(input logic [15:0] l);
    return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
  endfunction

  function automatic logic [2:0] model_type(input logic [2:0] t, input logic birds);
    logic [2:0] r;
    case (t)
      3'd0: r = 3'd0; 3'd1: r = 3'd1; 3'd2: r = 3'd2; 3'd3: r = 3'd3;
      3'd4: r = 3'd4; 3'd5: r = 3'd1; 3'd6: r = 3'd2; default: r = 3'd3;
    endcase
    if (!birds && r < 3'd2) r = r + 3'd2;
    return r;
  endfunction

  logic [15:0] m_lfsr;
  always @(posedge clk) m_lfsr <= rst ? 16'hACE1 : model_step(m_lfsr);

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    cycle();
    tick = 1'b0;
    cycle();
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; halt = 1'b0; tick = 1'b0; speed = 4'd0;
    repeat (3) cycle();
    checks++;
    if ({en1, en2, en3} !== 3'b000) begin failures++; $display("FAIL reset_en got %b want 000", {en1, en2, en3}); end
    checks++;
    if ({pos1, pos2, pos3} !== 30'd0) begin failures++; $display("FAIL reset_pos got %0d %0d %0d want 0 0 0", pos1, pos2, pos3); end
    checks++;
    if ({type1, type2, type3} !== {3'd5, 3'd5, 3'd5}) begin failures++; $display("FAIL reset_type got %0d %0d %0d want 5 5 5", type1, type2, type3); end
    checks++;
    if (running !== 1'b0 || st !== IDLE) begin failures++; $display("FAIL reset_state got run=%b st=%0d want run=0 st=0", running, st); end
    checks++;
    if (dut.lfsr !== 16'hACE1) begin failures++; $display("FAIL reset_lfsr got %h want ace1", dut.lfsr); end
    checks++;
    if (dut.gap !== 8'd0) begin failures++; $display("FAIL reset_gap got %0d want 0", dut.gap); end
    rst = 1'b0;
    cycle();
  endtask

  task automatic test_first_spawn();
    logic [15:0] l;
    speed = 4'd4;
    start = 1'b1;
    cycle();
    start = 1'b0;
    checks++;
    if (running !== 1'b1 || dut.gap !== 8'd40) begin failures++; $display("FAIL start_run got run=%b gap=%0d want run=1 gap=40", running, dut.gap); end
    repeat (5) cycle();
    checks++;
    if (dut.gap !== 8'd40 || en1 !== 1'b0) begin failures++; $display("FAIL idle_hold got gap=%0d en1=%b want 40 0", dut.gap, en1); end
    for (int i = 0; i < 40; i++) do_tick();
    checks++;
    if (en1 !== 1'b0 || dut.gap !== 8'd0) begin failures++; $display("FAIL tick40 got en1=%b gap=%0d want 0 0", en1, dut.gap); end
    l = m_lfsr;
    tick = 1'b1;
    cycle();
    tick = 1'b0;
    checks++;
    if (en1 !== 1'b1 || pos1 !== 10'd700) begin failures++; $display("FAIL spawn1 got en=%b pos=%0d want 1 700", en1, pos1); end
    checks++;
    if (type1 !== model_type(l[2:0], 1'b1)) begin failures++; $display("FAIL spawn1_type got %0d want %0d", type1, model_type(l[2:0], 1'b1)); end
    checks++;
    if ({en2, en3} !== 2'b00 || type2 !== 3'd5) begin failures++; $display("FAIL spawn1_others got en2=%b en3=%b t2=%0d want 0 0 5", en2, en3, type2); end
    checks++;
    if (dut.gap !== 8'(40 + l[9:4])) begin failures++; $display("FAIL spawn1_gap got %0d want %0d", dut.gap, 40 + l[9:4]); end
    cycle();
  endtask

  task automatic test_scroll_retire();
    for (int i = 0; i < 174; i++) do_tick();
    checks++;
    if (en1 !== 1'b1 || pos1 !== 10'd4) begin failures++; $display("FAIL scroll174 got en=%b pos=%0d want 1 4", en1, pos1); end
    do_tick();
    checks++;
    if (en1 !== 1'b1 || pos1 !== 10'd0) begin failures++; $display("FAIL scroll_zero got en=%b pos=%0d want 1 0", en1, pos1); end
    do_tick();
    checks++;
    if (en1 !== 1'b0 || pos1 !== 10'd0 || type1 !== 3'd5) begin failures++; $display("FAIL retire got en=%b pos=%0d type=%0d want 0 0 5", en1, pos1, type1); end
  endtask

  task automatic test_slots_full();
    logic [15:0] l;
    logic [9:0]  p1, p2, p3;
    int n;
    speed = 4'd1;
    start = 1'b1;
    cycle();
    start = 1'b0;
    n = 0;
    while (en3 !== 1'b1 && n < 600) begin do_tick(); n++; end
    checks++;
    if ({en1, en2, en3} !== 3'b111) begin failures++; $display("FAIL fill_timeout got en=%b want 111", {en1, en2, en3}); end
    speed = 4'd0;
    n = 0;
    while (dut.gap !== 8'd0 && n < 120) begin do_tick(); n++; end
    p1 = pos1; p2 = pos2; p3 = pos3;
    repeat (5) do_tick();
    checks++;
    if (dut.gap !== 8'd0 || {en1, en2, en3} !== 3'b111) begin failures++; $display("FAIL full_hold got gap=%0d en=%b want 0 111", dut.gap, {en1, en2, en3}); end
    checks++;
    if (pos1 !== p1 || pos2 !== p2 || pos3 !== p3) begin failures++; $display("FAIL speed0 got %0d %0d %0d want %0d %0d %0d", pos1, pos2, pos3, p1, p2, p3); end
    speed = 4'd15;
    n = 0;
    while (en1 !== 1'b0 && n < 100) begin do_tick(); n++; end
    checks++;
    if ({en1, en2, en3} !== 3'b011 || dut.gap !== 8'd0) begin failures++; $display("FAIL retire_one got en=%b gap=%0d want 011 0", {en1, en2, en3}, dut.gap); end
    l = m_lfsr;
    tick = 1'b1;
    cycle();
    tick = 1'b0;
    checks++;
    if (en1 !== 1'b1 || pos1 !== 10'd700 || type1 !== model_type(l[2:0], 1'b1)) begin
      failures++; $display("FAIL respawn got en=%b pos=%0d type=%0d want 1 700 %0d", en1, pos1, type1, model_type(l[2:0], 1'b1));
    end
    checks++;
    if (dut.gap !== 8'(40 + l[9:4])) begin failures++; $display("FAIL respawn_gap got %0d want %0d", dut.gap, 40 + l[9:4]); end
    cycle();
  endtask

  task automatic test_halt();
    logic [9:0] p1, p2, p3;
    p1 = pos1; p2 = pos2; p3 = pos3;
    halt = 1'b1; tick = 1'b1;
    cycle();
    halt = 1'b0; tick = 1'b0;
    checks++;
    if (pos1 !== p1 || pos2 !== p2 || pos3 !== p3 || st !== STOP || running !== 1'b0) begin
      failures++; $display("FAIL halt_tick got %0d %0d %0d st=%0d want %0d %0d %0d st=2", pos1, pos2, pos3, st, p1, p2, p3);
    end
    repeat (10) do_tick();
    checks++;
    if (pos1 !== p1 || pos2 !== p2 || pos3 !== p3 || {en1, en2, en3} !== 3'b111) begin
      failures++; $display("FAIL stop_frozen got %0d %0d %0d en=%b want %0d %0d %0d en=111", pos1, pos2, pos3, {en1, en2, en3}, p1, p2, p3);
    end
    start = 1'b1;
    cycle();
    start = 1'b0;
    checks++;
    if ({en1, en2, en3} !== 3'b000 || {pos1, pos2, pos3} !== 30'd0 || {type1, type2, type3} !== {3'd5, 3'd5, 3'd5}) begin
      failures++; $display("FAIL restart_clear got en=%b pos=%0d %0d %0d", {en1, en2, en3}, pos1, pos2, pos3);
    end
    checks++;
    if (running !== 1'b1 || dut.gap !== 8'd40) begin failures++; $display("FAIL restart_run got run=%b gap=%0d want 1 40", running, dut.gap); end
  endtask

  task automatic test_precedence();
    do_tick();
    start = 1'b1; halt = 1'b1; tick = 1'b1;
    cycle();
    start = 1'b0;
    checks++;
    if (st !== RUN || dut.gap !== 8'd40) begin failures++; $display("FAIL start_over_halt got st=%0d gap=%0d want 1 40", st, dut.gap); end
    cycle();
    halt = 1'b0; tick = 1'b0;
    checks++;
    if (st !== STOP || dut.gap !== 8'd40) begin failures++; $display("FAIL halt_over_tick got st=%0d gap=%0d want 2 40", st, dut.gap); end
    rst = 1'b1; start = 1'b1; tick = 1'b1;
    cycle();
    rst = 1'b0; start = 1'b0; tick = 1'b0;
    checks++;
    if (st !== IDLE || dut.gap !== 8'd0 || dut.lfsr !== 16'hACE1 || running !== 1'b0) begin
      failures++; $display("FAIL rst_midrun got st=%0d gap=%0d lfsr=%h want 0 0 ace1", st, dut.gap, dut.lfsr);
    end
  endtask

  task automatic test_type_map();
    logic [2:0] pe1, pe0, ce1, ce0;
    logic [2:0] ty1 [3];
    logic [2:0] ty0 [3];
    logic [9:0] ps1 [3];
    logic [7:0] seen1, seen0;
    int spawns1, spawns0, badpos;
    seen1 = '0; seen0 = '0; spawns1 = 0; spawns0 = 0; badpos = 0;
    t_rst = 1'b1;
    repeat (2) cycle();
    t_rst = 1'b0; t_start = 1'b1;
    cycle();
    t_start = 1'b0; t_tick = 1'b1;
    pe1 = 3'b000; pe0 = 3'b000;
    for (int c = 0; c < 20000; c++) begin
      cycle();
      ce1 = {b1_e3, b1_e2, b1_e1}; ce0 = {b0_e3, b0_e2, b0_e1};
      ty1[0] = b1_t1; ty1[1] = b1_t2; ty1[2] = b1_t3;
      ty0[0] = b0_t1; ty0[1] = b0_t2; ty0[2] = b0_t3;
      ps1[0] = b1_p1; ps1[1] = b1_p2; ps1[2] = b1_p3;
      for (int s = 0; s < 3; s++) begin
        if (ce1[s] && !pe1[s]) begin spawns1++; seen1[ty1[s]] = 1'b1; if (ps1[s] !== 10'd700) badpos++; end
        if (ce0[s] && !pe0[s]) begin spawns0++; seen0[ty0[s]] = 1'b1; end
      end
      pe1 = ce1; pe0 = ce0;
    end
    t_tick = 1'b0;
    checks++;
    if (spawns1 < 300 || spawns0 !== spawns1) begin failures++; $display("FAIL spawn_count got b1=%0d b0=%0d want >=300 equal", spawns1, spawns0); end
    checks++;
    if (seen1 !== 8'b0001_1111) begin failures++; $display("FAIL types_birds got mask=%b want 00011111", seen1); end
    checks++;
    if (seen0 !== 8'b0001_1100) begin failures++; $display("FAIL types_nobirds got mask=%b want 00011100", seen0); end
    checks++;
    if (badpos !== 0) begin failures++; $display("FAIL spawn_pos got %0d bad spawns want 0", badpos); end
  endtask

  initial begin
    test_reset();
    test_first_spawn();
    test_scroll_retire();
    test_slots_full();
    test_halt();
    test_precedence();
    test_type_map();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
